spi_reg_controller: RTL

Command controller sequencing the SPI slave byte datapath. It decodes received bytes into register read/write transactions on an internal bank of NUM_REGS 8-bit control registers, and schedules the reply byte loaded into the slave's transmit path. The block sits between the SPI slave (rx byte / rx valid / tx byte / tx valid) and the board logic (LEDs, GPIO config), which consumes the exported register contents.

---
 rtl/spi_reg_controller_if.sv | 18 +
 rtl/spi_reg_controller.sv | 133 +++++++++++++
 2 files changed

// File: rtl/spi_reg_controller_if.sv
// rtl/spi_reg_controller_if.sv - SPI slave byte-path bundle between the slave core and the command controller
interface spi_reg_controller_if;
  logic       spi_cs;
  logic [7:0] spi_rx_data;
  logic       spi_rx_valid;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid;

  modport master (
    output spi_cs, spi_rx_data, spi_rx_valid,
    input  spi_tx_data, spi_tx_valid
  );

  modport slave (
    input  spi_cs, spi_rx_data, spi_rx_valid,
    output spi_tx_data, spi_tx_valid
  );
endinterface

// File: rtl/spi_reg_controller.sv
// rtl/spi_reg_controller.sv - SPI command decoder driving an 8-bit control register bank and reply scheduling
module spi_reg_controller #(
  parameter int         NUM_REGS  = 8,
  parameter logic [6:0] STATUS_ID = 7'h2A
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_reg_controller_if.slave   spi,
  output logic [NUM_REGS*8-1:0] reg_q,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic                  frame_active,
  output logic                  err
);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WRITE, S_READ} state_t;

  state_t     r_state;
  logic [2:0] r_cs_sync;
  logic [6:0] r_addr;
  logic [7:0] r_regs [NUM_REGS];
  logic [7:0] r_tx_data;
  logic       r_tx_valid;
  logic       r_wr_strobe;
  logic [6:0] r_wr_addr;
  logic       r_frame_active;
  logic       r_err;

  logic       w_cs_fall;
  logic       w_cs_rise;
  logic       w_rx_take;
  logic       w_wr_en;
  logic       w_err_set;
  logic [6:0] w_addr_next;
  logic [6:0] w_rd_addr;
  logic [7:0] w_rd_data;

  function automatic logic in_range(input logic [6:0] a);
    return ({1'b0, a} < 8'(NUM_REGS));
  endfunction

  assign w_cs_fall   = (r_cs_sync[2:1] == 2'b10);
  assign w_cs_rise   = (r_cs_sync[2:1] == 2'b01);
  assign w_rx_take   = spi.spi_rx_valid && (r_state != S_IDLE);
  assign w_addr_next = r_addr + 7'd1;
  assign w_wr_en     = w_rx_take && (r_state == S_WRITE) && in_range(r_addr);

  // The command byte reads at its own address; streaming reads prefetch the next address.
  always_comb begin
    w_rd_addr = (r_state == S_CMD) ? spi.spi_rx_data[6:0] : w_addr_next;
    w_rd_data = in_range(w_rd_addr) ? r_regs[w_rd_addr[AW-1:0]] : 8'h00;
    w_err_set = 1'b0;
    if (w_rx_take) begin
      unique case (r_state)
        S_CMD:   w_err_set = !spi.spi_rx_data[7] && !in_range(w_rd_addr);
        S_WRITE: w_err_set = !in_range(r_addr);
        S_READ:  w_err_set = !in_range(w_rd_addr);
        default: w_err_set = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_cs_sync      <= 3'b111;
      r_addr         <= 7'd0;
      r_tx_data      <= 8'h00;
      r_tx_valid     <= 1'b0;
      r_wr_strobe    <= 1'b0;
      r_wr_addr      <= 7'd0;
      r_frame_active <= 1'b0;
      r_err          <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      r_cs_sync   <= {r_cs_sync[1:0], spi.spi_cs};
      r_tx_valid  <= 1'b0;
      r_wr_strobe <= 1'b0;

      // Byte side effects land even when chip select rises in the same cycle.
      if (w_wr_en) begin
        r_regs[r_addr[AW-1:0]] <= spi.spi_rx_data;
        r_wr_strobe            <= 1'b1;
        r_wr_addr              <= r_addr;
      end
      if (w_rx_take) begin
        r_addr <= (r_state == S_CMD) ? spi.spi_rx_data[6:0] : w_addr_next;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end

      if (w_cs_fall) begin
        r_state        <= S_CMD;
        r_frame_active <= 1'b1;
        r_tx_valid     <= 1'b1;
        r_tx_data      <= {r_err, STATUS_ID};
        r_err          <= w_err_set;
      end else if (w_cs_rise && (r_state != S_IDLE)) begin
        r_state        <= S_IDLE;
        r_frame_active <= 1'b0;
      end else if (w_rx_take) begin
        r_tx_valid <= 1'b1;
        unique case (r_state)
          S_CMD: begin
            r_state   <= spi.spi_rx_data[7] ? S_WRITE : S_READ;
            r_tx_data <= spi.spi_rx_data[7] ? 8'h00 : w_rd_data;
          end
          S_WRITE: r_tx_data <= 8'h00;
          S_READ:  r_tx_data <= w_rd_data;
          default: begin
            r_state    <= S_IDLE;
            r_tx_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[8*g +: 8] = r_regs[g];
  end

  assign spi.spi_tx_data  = r_tx_data;
  assign spi.spi_tx_valid = r_tx_valid;
  assign wr_strobe        = r_wr_strobe;
  assign wr_addr          = r_wr_addr;
  assign frame_active     = r_frame_active;
  assign err              = r_err;
endmodule
